// File: rtl/xhdmi_pkg.sv
// Shared types and constants for the HDMI TMDS lane aligner.
package xhdmi_pkg;

   typedef enum logic [1:0] {
      SLIP   = 2'd0,
      SWEEP  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [9:0] TOK0 = 10'h354;
   localparam logic [9:0] TOK1 = 10'h0AB;
   localparam logic [9:0] TOK2 = 10'h154;
   localparam logic [9:0] TOK3 = 10'h2AB;

   localparam int NTAPS  = 32;
   localparam int NSHIFT = 10;

   function automatic logic is_token(input logic [9:0] w);
      return (w == TOK0) || (w == TOK1) ||
             (w == TOK2) || (w == TOK3);
   endfunction

endpackage

// File: rtl/xhdmiin_tokdet.sv
// Word rotator and TMDS control-token detector.
// o_word lags i_word by one clock, o_hit lags o_word by one more.
module xhdmiin_tokdet
   import xhdmi_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [9:0] i_word,
   input  logic [3:0] i_shift,
   output logic [9:0] o_word,
   output logic       o_hit
);

   logic [9:0]  prev_word;
   logic [19:0] win;
   logic [19:0] rot;

   assign win = {i_word, prev_word};
   assign rot = win >> i_shift;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         prev_word <= '0;
         o_word    <= '0;
         o_hit     <= 1'b0;
      end else begin
         prev_word <= i_word;
         o_word    <= rot[9:0];
         o_hit     <= is_token(o_word);
      end
   end

endmodule

// File: rtl/xhdmiin_align.sv
// Per-lane HDMI link trainer: word slip, delay-tap eye sweep, lock monitor.
// Define XHDMI_ALIGN_EYE_EN to expose the o_eye good-tap bitmap.
module xhdmiin_align
   import xhdmi_pkg::*;
#(
   parameter int LGDWELL    = 10,
   parameter int SETTLE     = 16,
   parameter int THRESH     = 4,
   parameter int MIN_EYE    = 4,
   parameter int LOSS_LIMIT = 4,
   parameter int INIT_DELAY = 16
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_restart,
   input  logic [9:0] i_word,
   output logic [4:0] o_delay,
   output logic [3:0] o_shift,
   output logic [9:0] o_word,
   output logic       o_locked
`ifdef XHDMI_ALIGN_EYE_EN
   ,
   output logic [NTAPS-1:0] o_eye
`endif
);

   localparam int HW = LGDWELL + 1;

   state_t             state;
   logic [7:0]         settle_cnt;
   logic [LGDWELL-1:0] dwell_cnt;
   logic [HW-1:0]      hits;
   logic [HW-1:0]      hits_fin;
   logic [7:0]         miss_cnt;
   logic [7:0]         miss_n;
   logic [5:0]         run_len;
   logic [4:0]         run_start;
   logic [5:0]         best_len;
   logic [4:0]         best_start;
   logic [5:0]         run_len_n;
   logic [4:0]         run_start_n;
   logic [5:0]         best_len_n;
   logic [4:0]         best_start_n;
   logic [4:0]         centre;
   logic               hit;
   logic               settling;
   logic               wend;
   logic               good;
   logic               longer;
   logic               eye_ok;
   logic               tap_last;
   logic               lost;

   xhdmiin_tokdet u_tokdet (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_word    (i_word),
      .i_shift   (o_shift),
      .o_word    (o_word),
      .o_hit     (hit)
   );

   assign settling = (settle_cnt != 8'd0);
   assign wend     = !settling && (dwell_cnt == '1);
   assign hits_fin = (hits == '1) ? hits
                   : hits + {{(HW-1){1'b0}}, hit};
   assign good     = (hits_fin >= HW'(THRESH));
   assign tap_last = (o_delay == 5'(NTAPS - 1));

   // A run only extends on a good tap; tap 31 never joins tap 0.
   assign run_len_n   = good ? run_len + 6'd1 : 6'd0;
   assign run_start_n = (run_len == 6'd0) ? o_delay : run_start;
   assign longer      = good && (run_len_n > best_len);
   assign best_len_n  = longer ? run_len_n : best_len;
   assign best_start_n = longer ? run_start_n : best_start;
   assign centre      = best_start_n + best_len_n[5:1];
   assign eye_ok      = (best_len_n >= 6'(MIN_EYE));

   assign miss_n = miss_cnt + 8'd1;
   assign lost   = (hits_fin == '0) && (miss_n == 8'(LOSS_LIMIT));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= SLIP;
         o_delay    <= 5'(INIT_DELAY);
         o_shift    <= '0;
         o_locked   <= 1'b0;
         settle_cnt <= 8'(SETTLE);
         dwell_cnt  <= '0;
         hits       <= '0;
         miss_cnt   <= '0;
         run_len    <= '0;
         run_start  <= '0;
         best_len   <= '0;
         best_start <= '0;
      end else if (i_restart) begin
         state      <= SLIP;
         o_delay    <= 5'(INIT_DELAY);
         o_shift    <= '0;
         o_locked   <= 1'b0;
         settle_cnt <= 8'(SETTLE);
         dwell_cnt  <= '0;
         hits       <= '0;
         miss_cnt   <= '0;
         run_len    <= '0;
         run_start  <= '0;
         best_len   <= '0;
         best_start <= '0;
      end else begin
         if (settling) begin
            settle_cnt <= settle_cnt - 8'd1;
         end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
            hits      <= hits_fin;
         end
         if (wend) begin
            hits <= '0;
            unique case (state)
               SLIP: begin
                  settle_cnt <= 8'(SETTLE);
                  if (good) begin
                     state      <= SWEEP;
                     o_delay    <= '0;
                     run_len    <= '0;
                     run_start  <= '0;
                     best_len   <= '0;
                     best_start <= '0;
                  end else if (o_shift == 4'(NSHIFT - 1)) begin
                     o_shift <= '0;
                  end else begin
                     o_shift <= o_shift + 4'd1;
                  end
               end
               SWEEP: begin
                  settle_cnt <= 8'(SETTLE);
                  run_len    <= run_len_n;
                  run_start  <= run_start_n;
                  best_len   <= best_len_n;
                  best_start <= best_start_n;
                  if (!tap_last) begin
                     o_delay <= o_delay + 5'd1;
                  end else if (eye_ok) begin
                     state    <= LOCKED;
                     o_locked <= 1'b1;
                     o_delay  <= centre;
                     miss_cnt <= '0;
                  end else begin
                     state   <= SLIP;
                     o_shift <= '0;
                     o_delay <= 5'(INIT_DELAY);
                  end
               end
               LOCKED: begin
                  if (hits_fin != '0) begin
                     miss_cnt <= '0;
                  end else if (lost) begin
                     state      <= SLIP;
                     o_locked   <= 1'b0;
                     o_shift    <= '0;
                     o_delay    <= 5'(INIT_DELAY);
                     settle_cnt <= 8'(SETTLE);
                     miss_cnt   <= '0;
                  end else begin
                     miss_cnt <= miss_n;
                  end
               end
               default: begin
                  state <= SLIP;
               end
            endcase
         end
      end
   end

`ifdef XHDMI_ALIGN_EYE_EN
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_eye <= '0;
      end else if (!i_restart && wend) begin
         if (state == SLIP && good) begin
            o_eye <= '0;
         end else if (state == SWEEP) begin
            o_eye[o_delay] <= good;
         end
      end
   end
`endif

endmodule

// File: tb/tb_xhdmiin_align.sv
// Directed bench for xhdmiin_align with a tap-dependent lane data model.
module tb_xhdmiin_align;

   localparam int LGD = 6;
   localparam int W   = 1 << LGD;

   logic       i_clk = 1'b0;
   logic       i_reset_n;
   logic       i_restart;
   logic [9:0] i_word;
   logic [4:0] o_delay;
   logic [3:0] o_shift;
   logic [9:0] o_word;
   logic       o_locked;
`ifdef XHDMI_ALIGN_EYE_EN
   logic [31:0] o_eye;
`endif

   // 10'h354 rotated left by 3: aligned at shift 3 only.
   localparam logic [9:0] RAW = 10'h2A6;

   logic [31:0] map;
   bit          map_on;
   bit          zero_data;
   int          n_tests;
   int          n_fail;
   bit          ok;
   int          t;

   xhdmiin_align #(.LGDWELL(LGD)) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_restart (i_restart),
      .i_word    (i_word),
      .o_delay   (o_delay),
      .o_shift   (o_shift),
      .o_word    (o_word),
      .o_locked  (o_locked)
`ifdef XHDMI_ALIGN_EYE_EN
      ,
      .o_eye     (o_eye)
`endif
   );

   initial forever #5 i_clk = ~i_clk;

   // Noise is all-0/all-1 words, which can never form a token.
   initial begin
      i_word = '0;
      forever begin
         @(negedge i_clk);
         if (zero_data)
            i_word = '0;
         else if (!map_on || map[o_delay])
            i_word = RAW;
         else
            i_word = ($urandom_range(0, 1) == 1) ? 10'h3FF : 10'h000;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_lock(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge i_clk);
         if (o_locked) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_delay(input logic [4:0] v, input int budget,
                             output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge i_clk);
         if (o_delay == v) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic restart_with(input logic [31:0] m);
      @(negedge i_clk);
      map_on    = 1'b0;
      map       = m;
      i_restart = 1'b1;
      @(negedge i_clk);
      i_restart = 1'b0;
      wait_delay(5'd0, 3000, ok);
      chk("sweep_start", 32'(ok), 1);
      map_on = 1'b1;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      map       = '1;
      map_on    = 1'b0;
      zero_data = 1'b0;
      i_restart = 1'b0;
      i_reset_n = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("rst_delay", 32'(o_delay), 16);
      chk("rst_shift", 32'(o_shift), 0);
      chk("rst_word", 32'(o_word), 0);
      chk("rst_locked", 32'(o_locked), 0);
`ifdef XHDMI_ALIGN_EYE_EN
      chk("rst_eye", o_eye, 0);
`endif
      i_reset_n = 1'b1;

      // All taps clean: eye 0..31, centre 0 + 32/2.
      wait_lock(6000, ok);
      chk("t1_lock", 32'(ok), 1);
      chk("t1_shift", 32'(o_shift), 3);
      chk("t1_delay", 32'(o_delay), 16);
      chk("t1_word", 32'(o_word), 32'h354);
`ifdef XHDMI_ALIGN_EYE_EN
      chk("t1_eye", o_eye, 32'hFFFF_FFFF);
`endif
      repeat (5 * W) @(negedge i_clk);
      chk("t1_hold", 32'(o_locked), 1);

      // Loss of lock on dead data.
      zero_data = 1'b1;
      t = 0;
      ok = 1'b0;
      for (int i = 0; i < 8 * W; i++) begin
         @(negedge i_clk);
         t++;
         if (!o_locked) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t5_drop", 32'(ok), 1);
      chk("t5_time", 32'((t > 4 * W) && (t <= 5 * W + 4)), 1);
      chk("t5_shift", 32'(o_shift), 0);
      chk("t5_delay", 32'(o_delay), 16);

      // Restart in the middle of SWEEP.
      zero_data = 1'b0;
      wait_delay(5'd5, 3000, ok);
      chk("t6_reach", 32'(ok), 1);
      i_restart = 1'b1;
      @(negedge i_clk);
      i_restart = 1'b0;
      chk("t6_shift", 32'(o_shift), 0);
      chk("t6_delay", 32'(o_delay), 16);
      chk("t6_locked", 32'(o_locked), 0);
      wait_lock(6000, ok);
      chk("t6_relock", 32'(ok), 1);
      chk("t6_rshift", 32'(o_shift), 3);

      // Async reset partway through a locked window.
      repeat (W / 2 + 7) @(negedge i_clk);
      i_reset_n = 1'b0;
      repeat (2) @(negedge i_clk);
      chk("t7_shift", 32'(o_shift), 0);
      chk("t7_delay", 32'(o_delay), 16);
      chk("t7_locked", 32'(o_locked), 0);
      chk("t7_word", 32'(o_word), 0);
      i_reset_n = 1'b1;
      wait_lock(6000, ok);
      chk("t7_relock", 32'(ok), 1);
      chk("t7_rdelay", 32'(o_delay), 16);
      chk("t7_rword", 32'(o_word), 32'h354);

      // Eye at taps 8..19: centre 8 + 12/2.
      restart_with(32'h000F_FF00);
      wait_lock(6000, ok);
      chk("t2_lock", 32'(ok), 1);
      chk("t2_delay", 32'(o_delay), 14);
`ifdef XHDMI_ALIGN_EYE_EN
      chk("t2_eye", o_eye, 32'h000F_FF00);
`endif

      // Two 4-tap runs (2..5, 20..23): first wins, centre 2 + 2.
      restart_with(32'h00F0_003C);
      wait_lock(6000, ok);
      chk("t3_lock", 32'(ok), 1);
      chk("t3_delay", 32'(o_delay), 4);
`ifdef XHDMI_ALIGN_EYE_EN
      chk("t3_eye", o_eye, 32'h00F0_003C);
`endif

      // Only taps 10..12 good: too narrow, back to SLIP at tap 16.
      restart_with(32'h0000_1C00);
      wait_delay(5'd31, 4000, ok);
      chk("t4_reach31", 32'(ok), 1);
      wait_delay(5'd16, 200, ok);
      chk("t4_back", 32'(ok), 1);
      chk("t4_locked", 32'(o_locked), 0);
      chk("t4_shift", 32'(o_shift), 0);
`ifdef XHDMI_ALIGN_EYE_EN
      chk("t4_eye", o_eye, 32'h0000_1C00);
`endif
      repeat (20 * W) @(negedge i_clk);
      chk("t4_stay_lk", 32'(o_locked), 0);
      chk("t4_stay_dl", 32'(o_delay), 16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
